// File: rtl/debug_unit_defs.sv
// Shared debug-unit definitions: dump FSM state encodings,
// UART byte width and checksum seed.
package debug_unit_defs;

  localparam int         UART_BYTE_W   = 8;
  localparam logic [7:0] CHECKSUM_INIT = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_RD = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SEND    = 3'd3,
    ST_CHKSUM  = 3'd4,
    ST_FINISH  = 3'd5
  } dump_state_t;

endpackage

// File: rtl/register_dump_sequencer.sv
// Walks the register file over the debug read port and streams each
// register MSB-first to UART TX. Option: REG_DUMP_CHECKSUM_EN (XOR byte).
module register_dump_sequencer
  import debug_unit_defs::*;
#(
  parameter int CANTIDAD_REGISTROS              = 32,
  parameter int CANTIDAD_BITS_REGISTROS         = 32,
  parameter int CANTIDAD_BITS_ADDRESS_REGISTROS = 5,
  parameter int READ_LATENCY                    = 1
) (
  input  logic                                       i_clock,
  input  logic                                       i_reset,
  input  logic                                       i_start,
  output logic [CANTIDAD_BITS_ADDRESS_REGISTROS-1:0] o_reg_addr,
  input  logic [CANTIDAD_BITS_REGISTROS-1:0]         i_reg_data,
  output logic [7:0]                                 o_tx_data,
  output logic                                       o_tx_valid,
  input  logic                                       i_tx_ready,
  output logic                                       o_stall,
  output logic                                       o_busy,
  output logic                                       o_done
);

  localparam int AW = CANTIDAD_BITS_ADDRESS_REGISTROS;
  localparam int DW = CANTIDAD_BITS_REGISTROS;
  localparam int NB = DW / UART_BYTE_W;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  localparam logic [AW-1:0] LAST_ADDR = AW'(CANTIDAD_REGISTROS - 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(NB - 1);
  localparam logic [LW-1:0] LAST_LAT  = LW'(READ_LATENCY - 1);

  dump_state_t   state_q, state_n;
  logic [AW-1:0] addr_q;
  logic [BW-1:0] byte_cnt_q;
  logic [LW-1:0] lat_cnt_q;
  logic [DW-1:0] shift_q;
  logic [7:0]    tx_byte;
  logic          last_byte;
  logic          last_reg;
  logic          accept;

`ifdef REG_DUMP_CHECKSUM_EN
  logic [7:0]    chk_q;
`endif

  assign tx_byte    = shift_q[DW-1 -: 8];
  assign last_byte  = (byte_cnt_q == LAST_BYTE);
  assign last_reg   = (addr_q == LAST_ADDR);
  assign accept     = (state_q == ST_SEND) && i_tx_ready;
  assign o_reg_addr = addr_q;

  // State register; synchronous reset aborts any dump in progress.
  always_ff @(posedge i_clock) begin
    if (i_reset) state_q <= ST_IDLE;
    else         state_q <= state_n;
  end

  // Next state and Moore-style outputs decoded from the current state.
  always_comb begin
    state_n    = state_q;
    o_tx_valid = 1'b0;
    o_tx_data  = 8'h00;
    o_done     = 1'b0;
    o_busy     = (state_q != ST_IDLE);
    o_stall    = (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) state_n = ST_WAIT_RD;
      end
      ST_WAIT_RD: begin
        if (lat_cnt_q == LAST_LAT) state_n = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_n = ST_SEND;
      end
      ST_SEND: begin
        o_tx_valid = 1'b1;
        o_tx_data  = tx_byte;
        if (i_tx_ready && last_byte) begin
          if (!last_reg)
            state_n = ST_WAIT_RD;
          else
`ifdef REG_DUMP_CHECKSUM_EN
            state_n = ST_CHKSUM;
`else
            state_n = ST_FINISH;
`endif
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      ST_CHKSUM: begin
        o_tx_valid = 1'b1;
        o_tx_data  = chk_q;
        if (i_tx_ready) state_n = ST_FINISH;
      end
`endif
      ST_FINISH: begin
        o_done  = 1'b1;
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Address, latency and byte counters plus the output shift register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      addr_q     <= '0;
      byte_cnt_q <= '0;
      lat_cnt_q  <= '0;
      shift_q    <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            addr_q    <= '0;
            lat_cnt_q <= '0;
          end
        end
        ST_WAIT_RD: begin
          if (lat_cnt_q == LAST_LAT) lat_cnt_q <= '0;
          else                       lat_cnt_q <= lat_cnt_q + 1'b1;
        end
        ST_CAPTURE: begin
          shift_q    <= i_reg_data;
          byte_cnt_q <= '0;
        end
        ST_SEND: begin
          if (accept) begin
            shift_q    <= shift_q << UART_BYTE_W;
            byte_cnt_q <= byte_cnt_q + 1'b1;
            if (last_byte && !last_reg) addr_q <= addr_q + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef REG_DUMP_CHECKSUM_EN
  // Running XOR of every data byte accepted since the dump started.
  always_ff @(posedge i_clock) begin
    if (i_reset)
      chk_q <= CHECKSUM_INIT;
    else if (state_q == ST_IDLE && i_start)
      chk_q <= CHECKSUM_INIT;
    else if (accept)
      chk_q <= chk_q ^ tx_byte;
  end
`endif

endmodule
